if_prefetch_queue: RTL and testbench

Instruction-fetch front end that feeds the decode stage. It owns the fetch PC, issues in-order requests to instruction memory with a valid/ready handshake, and buffers returned instructions with their PC+4 in a small FIFO. It absorbs decode stalls and branch redirects resolved in ID. On a redirect it flushes queued instructions and discards in-flight responses.

---
 rtl/if_prefetch_queue.sv | 114 +++++++++++
 tb/tb_if_prefetch_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests
// to instruction memory, and buffers returned words together with their
// PC+4 in a small FIFO that feeds decode. Branch redirects from ID flush the
// FIFO and discard every response that is still in flight.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_id,
  output logic [31:0] pc_plus_four_id,
  input  logic        branch_id,
  input  logic [31:0] branch_target_id
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inst_q [DEPTH];
  logic [31:0]   r_pc4_q  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic          w_credit_ok;
  logic          w_accept;
  logic          w_pop;
  logic          w_redirect;
  logic          w_drop_rsp;
  logic          w_push;
  logic [31:0]   w_rsp_pc4;
  logic [CW-1:0] w_out_next;

  // Queued entries plus requests in flight never exceed DEPTH, so every
  // response that arrives is guaranteed a free slot.
  assign w_credit_ok    = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !branch_id && w_credit_ok;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign inst_valid      = !rst && (r_count != '0);
  assign inst_id         = r_inst_q[r_rd_ptr];
  assign pc_plus_four_id = r_pc4_q[r_rd_ptr];
  assign w_pop           = inst_valid && inst_ready;
  assign w_redirect      = w_pop && branch_id;

  // While nothing is being dropped, all in-flight requests are consecutive
  // words ending just below fetch_pc, so the oldest one sits at
  // fetch_pc - 4*outstanding.
  assign w_rsp_pc4  = r_fetch_pc - (32'(r_outstanding) << 2) + 32'd4;
  assign w_drop_rsp = imem_rsp_valid && (r_drop != '0);
  assign w_push     = imem_rsp_valid && (r_drop == '0) && !w_redirect;

  // Outstanding count after this cycle's accept and response.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_out_next = r_outstanding;
    if (w_accept)       w_out_next = w_out_next + CW'(1);
    if (imem_rsp_valid) w_out_next = w_out_next - CW'(1);
  end

  // Control state: fetch PC, FIFO pointers and the three counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redirect) begin
        // The branch itself pops; everything behind it and in flight dies.
        r_fetch_pc <= branch_target_id;
        r_drop     <= w_out_next;
        r_rd_ptr   <= r_wr_ptr;
        r_count    <= '0;
      end else begin
        if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop_rsp) r_drop     <= r_drop - CW'(1);
        if (w_push)     r_wr_ptr   <= r_wr_ptr + PW'(1);
        if (w_pop)      r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO payload storage, written on every accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is not reset; count gates its visibility, so stale contents are never observed.
    if (w_push) begin
      r_inst_q[r_wr_ptr] <= imem_rsp_data;
      r_pc4_q[r_wr_ptr]  <= w_rsp_pc4;
    end
  end

  // A response landing on a full queue means the memory broke the credit rule.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (r_count != CW'(DEPTH)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: an in-order memory model with configurable
// latency and ready pattern, and a decode model that knows which PC the next
// head must carry (sequential, or the branch target after a redirect).
`timescale 1ns/1ps
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_id, pc_plus_four_id;
  logic        branch_id;
  logic [31:0] branch_target_id;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_id          (inst_id),
    .pc_plus_four_id  (pc_plus_four_id),
    .branch_id        (branch_id),
    .branch_target_id (branch_target_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  // Memory model state
  mreq_t       mem_q[$];
  logic [31:0] req_log[$];
  bit          ready_script[$];
  int          cyc;
  int          mem_lat, ready_pct, dec_pct, br_pct, noise_pct;

  // Decode / architectural model state
  bit          br_armed;
  logic [31:0] br_armed_target;
  logic [31:0] exp_pc, fetch_exp;
  int          n_pops, stream_bad, fetch_bad;
  logic [31:0] bad_inst, bad_pc4, bad_exp_pc, bad_fetch_obs, bad_fetch_exp;
  logic [31:0] last_pop_inst, last_pop_pc4;
  int          last_redirect_cyc, last_pop_cyc;

  // Per-cycle samples
  logic        s_req_valid, s_inst_valid, s_rsp_valid, s_redirect;
  logic [31:0] s_req_addr, s_inst_id, s_pc4;

  int passed, total;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic clear_model();
    mem_q.delete();
    req_log.delete();
    ready_script.delete();
    exp_pc     = RESET_PC;
    fetch_exp  = RESET_PC;
    n_pops     = 0;
    stream_bad = 0;
    fetch_bad  = 0;
    br_armed   = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, update models.
  task automatic step();
    mreq_t m;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    s_rsp_valid = imem_rsp_valid;
    if (ready_script.size() > 0) imem_req_ready = ready_script.pop_front();
    else imem_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready       = ($urandom_range(99) < dec_pct);
    branch_id        = 1'b0;
    branch_target_id = $urandom;
    #1;
    s_inst_valid = inst_valid;
    s_inst_id    = inst_id;
    s_pc4        = pc_plus_four_id;
    s_redirect   = 1'b0;
    if (inst_valid && inst_ready) begin
      if (br_armed || ($urandom_range(99) < br_pct)) begin
        branch_id        = 1'b1;
        branch_target_id = br_armed ? br_armed_target :
                           (($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC));
        s_redirect = 1'b1;
        br_armed   = 1'b0;
      end
    end else if ($urandom_range(99) < noise_pct) begin
      branch_id = 1'b1;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    if (!rst) begin
      if (s_req_valid && imem_req_ready) begin
        if (s_req_addr !== fetch_exp && fetch_bad == 0) begin
          bad_fetch_obs = s_req_addr;
          bad_fetch_exp = fetch_exp;
        end
        if (s_req_addr !== fetch_exp) fetch_bad++;
        fetch_exp = s_req_addr + 32'd4;
        req_log.push_back(s_req_addr);
        mem_q.push_back('{addr: s_req_addr, due: cyc + mem_lat});
      end
      if (s_inst_valid && inst_ready) begin
        if ((s_inst_id !== inst_of(exp_pc) || s_pc4 !== exp_pc + 32'd4) && stream_bad == 0) begin
          bad_inst   = s_inst_id;
          bad_pc4    = s_pc4;
          bad_exp_pc = exp_pc;
        end
        if (s_inst_id !== inst_of(exp_pc) || s_pc4 !== exp_pc + 32'd4) stream_bad++;
        n_pops++;
        last_pop_inst = s_inst_id;
        last_pop_pc4  = s_pc4;
        last_pop_cyc  = cyc;
        if (s_redirect) begin
          exp_pc            = branch_target_id;
          fetch_exp         = branch_target_id;
          last_redirect_cyc = cyc;
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_lat   = 1;
    ready_pct = 100;
    dec_pct   = 0;
    br_pct    = 0;
    noise_pct = 0;
    clear_model();
    step();
    step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_lat = 1; ready_pct = 100; dec_pct = 0; br_pct = 0; noise_pct = 0;
    clear_model();
    step();
    total++; if (s_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", s_req_valid); else passed++;
    total++; if (s_inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", s_inst_valid); else passed++;
    step();
    rst = 1'b0;
    clear_model();
    step();
    total++; if (s_req_valid !== 1'b1) $display("FAIL reset_first_req_valid: got %b want 1", s_req_valid); else passed++;
    total++; if (s_req_addr !== RESET_PC) $display("FAIL reset_first_addr: got %h want %h", s_req_addr, RESET_PC); else passed++;
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int valid_cnt   = 0;
    do_reset();
    dec_pct = 100;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_inst_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = i;
      end
    end
    total++; if (first_valid !== 2) $display("FAIL stream_first_valid: got cycle %0d want 2", first_valid); else passed++;
    total++; if (valid_cnt !== 18) $display("FAIL stream_valid_count: got %0d want 18", valid_cnt); else passed++;
    total++; if (req_log.size() !== 20) $display("FAIL stream_req_count: got %0d want 20", req_log.size()); else passed++;
    for (int i = 0; i < req_log.size(); i++) begin
      total++;
      if (req_log[i] !== 32'(i * 4)) $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_log[i], 32'(i * 4));
      else passed++;
    end
    total++;
    if (stream_bad !== 0)
      $display("FAIL stream_heads: %0d bad, first inst=%h pc4=%h want inst=%h pc4=%h",
               stream_bad, bad_inst, bad_pc4, inst_of(bad_exp_pc), bad_exp_pc + 32'd4);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    repeat (10) step();
    total++; if (req_log.size() !== DEPTH) $display("FAIL stall_req_count: got %0d want %0d", req_log.size(), DEPTH); else passed++;
    for (int i = 0; i < req_log.size() && i < DEPTH; i++) begin
      total++;
      if (req_log[i] !== 32'(i * 4)) $display("FAIL stall_req_addr[%0d]: got %h want %h", i, req_log[i], 32'(i * 4));
      else passed++;
    end
    total++; if (s_req_valid !== 1'b0) $display("FAIL stall_req_valid_full: got %b want 0", s_req_valid); else passed++;
    total++; if (s_inst_valid !== 1'b1) $display("FAIL stall_inst_valid: got %b want 1", s_inst_valid); else passed++;
    dec_pct = 100;
    repeat (8) step();
    total++; if (n_pops !== 8) $display("FAIL stall_release_pops: got %0d want 8", n_pops); else passed++;
    total++;
    if (req_log.size() < 5) $display("FAIL stall_resume_addr: got %0d requests want at least 5", req_log.size());
    else if (req_log[4] !== 32'h10) $display("FAIL stall_resume_addr: got %h want 00000010", req_log[4]);
    else passed++;
    total++;
    if (stream_bad !== 0)
      $display("FAIL stall_heads: %0d bad, first inst=%h pc4=%h want inst=%h pc4=%h",
               stream_bad, bad_inst, bad_pc4, inst_of(bad_exp_pc), bad_exp_pc + 32'd4);
    else passed++;
  endtask

  task automatic test_redirect_inflight();
    bit seen = 1'b0;
    int log_at;
    int pops_at;
    do_reset();
    mem_lat = 3;
    dec_pct = 100;
    ready_script = '{1'b1, 1'b0, 1'b1, 1'b1};
    br_armed = 1'b1;
    br_armed_target = 32'h0000_0100;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = s_redirect;
    end
    total++; if (!seen) $display("FAIL redir_inflight_timeout: no head within 20 cycles"); else passed++;
    total++; if (mem_q.size() !== 2) $display("FAIL redir_inflight_outstanding: got %0d want 2", mem_q.size()); else passed++;
    total++; if (s_req_valid !== 1'b0) $display("FAIL redir_inflight_req_valid: got %b want 0", s_req_valid); else passed++;
    log_at  = req_log.size();
    pops_at = n_pops;
    for (int i = 0; i < 30 && n_pops == pops_at; i++) step();
    total++; if (n_pops == pops_at) $display("FAIL redir_inflight_refill_timeout: no head within 30 cycles"); else passed++;
    total++; if (last_pop_inst !== inst_of(32'h100)) $display("FAIL redir_inflight_inst: got %h want %h", last_pop_inst, inst_of(32'h100)); else passed++;
    total++; if (last_pop_pc4 !== 32'h104) $display("FAIL redir_inflight_pc4: got %h want 00000104", last_pop_pc4); else passed++;
    total++;
    if (req_log.size() <= log_at) $display("FAIL redir_inflight_req: no request after redirect");
    else if (req_log[log_at] !== 32'h100) $display("FAIL redir_inflight_req: got %h want 00000100", req_log[log_at]);
    else passed++;
  endtask

  task automatic test_redirect_same_cycle();
    int t;
    do_reset();
    dec_pct = 100;
    repeat (6) step();
    br_armed = 1'b1;
    br_armed_target = 32'h0000_2000;
    step();
    t = cyc - 1;
    total++; if (s_redirect !== 1'b1) $display("FAIL redir_same_taken: got %b want 1", s_redirect); else passed++;
    total++; if (s_rsp_valid !== 1'b1) $display("FAIL redir_same_rsp_present: got %b want 1", s_rsp_valid); else passed++;
    total++; if (s_req_valid !== 1'b0) $display("FAIL redir_same_req_valid: got %b want 0", s_req_valid); else passed++;
    step();
    total++; if (s_inst_valid !== 1'b0) $display("FAIL redir_same_flush_t1: got %b want 0", s_inst_valid); else passed++;
    total++; if ({s_req_valid, s_req_addr} !== {1'b1, 32'h2000}) $display("FAIL redir_same_target_req: got %b/%h want 1/00002000", s_req_valid, s_req_addr); else passed++;
    step();
    total++; if (s_inst_valid !== 1'b0) $display("FAIL redir_same_flush_t2: got %b want 0", s_inst_valid); else passed++;
    step();
    total++; if (s_inst_valid !== 1'b1) $display("FAIL redir_same_valid_t3: got %b want 1", s_inst_valid); else passed++;
    total++; if (s_inst_id !== inst_of(32'h2000)) $display("FAIL redir_same_inst_t3: got %h want %h", s_inst_id, inst_of(32'h2000)); else passed++;
    total++; if (last_pop_cyc - t !== 3) $display("FAIL redir_same_latency: got %0d want 3", last_pop_cyc - t); else passed++;
    total++;
    if (stream_bad !== 0)
      $display("FAIL redir_same_heads: %0d bad, first inst=%h pc4=%h want inst=%h pc4=%h",
               stream_bad, bad_inst, bad_pc4, inst_of(bad_exp_pc), bad_exp_pc + 32'd4);
    else passed++;
  endtask

  task automatic test_ready_low();
    logic [31:0] held;
    do_reset();
    dec_pct = 100;
    repeat (5) step();
    held = req_log[$] + 32'd4;
    ready_script = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({s_req_valid, s_req_addr} !== {1'b1, held})
        $display("FAIL ready_low_hold[%0d]: got %b/%h want 1/%h", i, s_req_valid, s_req_addr, held);
      else passed++;
    end
    repeat (10) step();
    total++; if (req_log.size() !== 15) $display("FAIL ready_low_req_count: got %0d want 15", req_log.size()); else passed++;
    total++;
    if (fetch_bad !== 0) $display("FAIL ready_low_seq: %0d bad, first got %h want %h", fetch_bad, bad_fetch_obs, bad_fetch_exp);
    else passed++;
    total++;
    if (stream_bad !== 0)
      $display("FAIL ready_low_heads: %0d bad, first inst=%h pc4=%h want inst=%h pc4=%h",
               stream_bad, bad_inst, bad_pc4, inst_of(bad_exp_pc), bad_exp_pc + 32'd4);
    else passed++;
    total++; if (n_pops < 10) $display("FAIL ready_low_pops: got %0d want at least 10", n_pops); else passed++;
  endtask

  task automatic test_reset_full();
    do_reset();
    repeat (8) step();
    total++; if (s_inst_valid !== 1'b1) $display("FAIL rstfull_precond: got %b want 1", s_inst_valid); else passed++;
    rst = 1'b1;
    clear_model();
    step();
    total++; if (s_inst_valid !== 1'b0) $display("FAIL rstfull_inst_valid: got %b want 0", s_inst_valid); else passed++;
    total++; if (s_req_valid !== 1'b0) $display("FAIL rstfull_req_valid: got %b want 0", s_req_valid); else passed++;
    step();
    rst = 1'b0;
    clear_model();
    step();
    total++; if (s_inst_valid !== 1'b0) $display("FAIL rstfull_after_inst_valid: got %b want 0", s_inst_valid); else passed++;
    total++; if ({s_req_valid, s_req_addr} !== {1'b1, RESET_PC}) $display("FAIL rstfull_first_req: got %b/%h want 1/%h", s_req_valid, s_req_addr, RESET_PC); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      mem_lat   = $urandom_range(4, 1);
      ready_pct = $urandom_range(100, 40);
      dec_pct   = $urandom_range(100, 30);
      br_pct    = 10;
      noise_pct = 15;
      repeat (400) step();
    end
    total++;
    if (stream_bad !== 0)
      $display("FAIL random_heads: %0d bad, first inst=%h pc4=%h want inst=%h pc4=%h",
               stream_bad, bad_inst, bad_pc4, inst_of(bad_exp_pc), bad_exp_pc + 32'd4);
    else passed++;
    total++;
    if (fetch_bad !== 0) $display("FAIL random_fetch_addr: %0d bad, first got %h want %h", fetch_bad, bad_fetch_obs, bad_fetch_exp);
    else passed++;
    total++; if (n_pops < 100) $display("FAIL random_progress: got %0d pops want at least 100", n_pops); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    rst    = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; branch_id = 1'b0; branch_target_id = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_ready_low();
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
